// File: rtl/rename_pkg.sv
// Shared types and sizing for the register rename stage: tag/arch widths,
// map-table and free-list storage shapes, and the renamed-op bundle.
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int TAG_WIDTH = 6;
  localparam int FL_DEPTH  = 32;
  localparam int ARCH_W    = 5;
  localparam int FL_PTR_W  = 5;

  typedef logic [TAG_WIDTH-1:0] PhysTag;
  typedef logic [ARCH_W-1:0]    ArchReg;
  typedef logic [FL_PTR_W-1:0]  FlPtr;

  typedef logic [ARCH_REGS-1:0][TAG_WIDTH-1:0] MapTable;
  typedef logic [FL_DEPTH-1:0][TAG_WIDTH-1:0]  FreeListMem;

  typedef struct packed {
    logic   uses_rs;
    PhysTag rs_tag;
    logic   uses_rt;
    PhysTag rt_tag;
    logic   uses_rw;
    PhysTag rw_tag;
    PhysTag old_rw_tag;
  } RenamedOp;

  function automatic MapTable identity_map();
    MapTable m;
    for (int i = 0; i < ARCH_REGS; i++) m[i] = PhysTag'(i);
    return m;
  endfunction

  // Tags above the architectural range form the initial free pool, in order.
  function automatic FreeListMem initial_free_list();
    FreeListMem f;
    for (int i = 0; i < FL_DEPTH; i++) f[i] = PhysTag'(ARCH_REGS + i);
    return f;
  endfunction
endpackage

// File: rtl/register_rename_stage_if.sv
// Decoder-to-rename and rename-to-instruction-queue handshake bundle.
interface register_rename_stage_if;
  logic                  in_valid;
  logic                  in_uses_rs;
  rename_pkg::ArchReg    in_rs_arch;
  logic                  in_uses_rt;
  rename_pkg::ArchReg    in_rt_arch;
  logic                  in_uses_rw;
  rename_pkg::ArchReg    in_rw_arch;
  logic                  in_ready;

  logic                  out_valid;
  logic                  out_uses_rs;
  rename_pkg::PhysTag    out_rs_tag;
  logic                  out_uses_rt;
  rename_pkg::PhysTag    out_rt_tag;
  logic                  out_uses_rw;
  rename_pkg::PhysTag    out_rw_tag;
  rename_pkg::PhysTag    out_old_rw_tag;
  logic                  iq_stall;

  modport master (
    output in_valid, in_uses_rs, in_rs_arch, in_uses_rt, in_rt_arch,
           in_uses_rw, in_rw_arch, iq_stall,
    input  in_ready, out_valid, out_uses_rs, out_rs_tag, out_uses_rt,
           out_rt_tag, out_uses_rw, out_rw_tag, out_old_rw_tag
  );

  modport slave (
    input  in_valid, in_uses_rs, in_rs_arch, in_uses_rt, in_rt_arch,
           in_uses_rw, in_rw_arch, iq_stall,
    output in_ready, out_valid, out_uses_rs, out_rs_tag, out_uses_rt,
           out_rt_tag, out_uses_rw, out_rw_tag, out_old_rw_tag
  );
endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical tags with a commit-side head checkpoint
// (retire_head) so a flush can rewind allocation in one cycle.
module rename_free_list
  import rename_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pop_i,
  input  logic       push_i,
  input  PhysTag     push_tag_i,
  input  logic       flush_i,
  output PhysTag     head_tag_o,
  output logic [5:0] free_count_o
);
  FreeListMem entries_q, entries_d;
  FlPtr       head_q, head_d;
  FlPtr       tail_q, tail_d;
  FlPtr       rhead_q, rhead_d;
  FlPtr       flush_diff;
  logic [5:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rhead_d   = rhead_q;
    count_d   = count_q;
    if (push_i) begin
      entries_d[tail_q] = push_tag_i;
      tail_d            = tail_q + 1'b1;
      rhead_d           = rhead_q + 1'b1;
    end
    flush_diff = tail_d - rhead_d;
    if (flush_i) begin
      // Equal pointers after a rewind mean every uncommitted tag came back: full.
      head_d  = rhead_d;
      count_d = (flush_diff == '0) ? 6'(FL_DEPTH) : {1'b0, flush_diff};
    end else begin
      if (pop_i) head_d = head_q + 1'b1;
      count_d = count_q + {5'b0, push_i} - {5'b0, pop_i};
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is reset on purpose -- its initial contents are the
      // free pool, so they are architecturally visible, unlike a plain data RAM.
      entries_q <= initial_free_list();
      head_q    <= '0;
      tail_q    <= '0;
      rhead_q   <= '0;
      count_q   <= 6'(FL_DEPTH);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      rhead_q   <= rhead_d;
      count_q   <= count_d;
    end
  end

  assign head_tag_o   = entries_q[head_q];
  assign free_count_o = count_q;
endmodule

// File: rtl/register_rename_stage.sv
// MIPS register rename stage: speculative/retirement map tables, per-tag
// ready bits and a one-deep registered output toward the instruction queue.
module register_rename_stage
  import rename_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  register_rename_stage_if.slave   bus,
  input  logic                     wb_valid,
  input  PhysTag                   wb_tag,
  input  logic                     commit_valid,
  input  ArchReg                   commit_rw_arch,
  input  PhysTag                   commit_rw_tag,
  input  PhysTag                   commit_old_tag,
  input  logic                     flush,
  output logic [PHYS_REGS-1:0]     phys_ready,
  output logic [5:0]               free_count
);
  MapTable              spec_map_q, spec_map_d;
  MapTable              retire_map_q, retire_map_d;
  logic [PHYS_REGS-1:0] phys_ready_q, phys_ready_d;
  RenamedOp             out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  logic   advance, accept, alloc;
  PhysTag head_tag;

  rename_free_list u_free_list (
    .clk          (clk),
    .rst_n        (rst_n),
    .pop_i        (accept & alloc),
    .push_i       (commit_valid),
    .push_tag_i   (commit_old_tag),
    .flush_i      (flush),
    .head_tag_o   (head_tag),
    .free_count_o (free_count)
  );

  // An empty free list blocks every instruction, even ones that allocate nothing.
  assign advance      = ~out_valid_q | ~bus.iq_stall;
  assign bus.in_ready = ~flush & advance & (free_count != '0);
  assign accept       = bus.in_valid & bus.in_ready;
  assign alloc        = bus.in_uses_rw & (bus.in_rw_arch != '0);

  always_comb begin
    retire_map_d = retire_map_q;
    if (commit_valid && commit_rw_arch != '0)
      retire_map_d[commit_rw_arch] = commit_rw_tag;

    spec_map_d = spec_map_q;
    if (flush)
      spec_map_d = retire_map_d;
    else if (accept && alloc)
      spec_map_d[bus.in_rw_arch] = head_tag;
  end

  // Writeback wakeup lands in the same update as allocation, so a reader
  // accepted alongside its producer's writeback never loses the wakeup.
  always_comb begin
    phys_ready_d = phys_ready_q;
    if (flush) begin
      phys_ready_d = '1;
    end else begin
      if (wb_valid)         phys_ready_d[wb_tag]   = 1'b1;
      if (accept && alloc)  phys_ready_d[head_tag] = 1'b0;
    end
    phys_ready_d[0] = 1'b1;
  end

  // Sources read the map before this instruction's own rw update.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d       = 1'b1;
      out_d.uses_rs     = bus.in_uses_rs;
      out_d.rs_tag      = bus.in_uses_rs ? spec_map_q[bus.in_rs_arch] : '0;
      out_d.uses_rt     = bus.in_uses_rt;
      out_d.rt_tag      = bus.in_uses_rt ? spec_map_q[bus.in_rt_arch] : '0;
      out_d.uses_rw     = bus.in_uses_rw;
      out_d.rw_tag      = alloc ? head_tag : '0;
      out_d.old_rw_tag  = alloc ? spec_map_q[bus.in_rw_arch] : '0;
    end else if (advance) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_map_q   <= identity_map();
      retire_map_q <= identity_map();
      phys_ready_q <= '1;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      spec_map_q   <= spec_map_d;
      retire_map_q <= retire_map_d;
      phys_ready_q <= phys_ready_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_uses_rs    = out_q.uses_rs;
  assign bus.out_rs_tag     = out_q.rs_tag;
  assign bus.out_uses_rt    = out_q.uses_rt;
  assign bus.out_rt_tag     = out_q.rt_tag;
  assign bus.out_uses_rw    = out_q.uses_rw;
  assign bus.out_rw_tag     = out_q.rw_tag;
  assign bus.out_old_rw_tag = out_q.old_rw_tag;
  assign phys_ready         = phys_ready_q;
endmodule

// File: tb/tb_register_rename_stage.sv
// Self-checking bench for register_rename_stage: a reference model predicts
// each renamed op into a scoreboard that is drained as the IQ consumes outputs.
module tb_register_rename_stage;
  import rename_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wb_valid;
  PhysTag               wb_tag;
  logic                 commit_valid;
  ArchReg               commit_rw_arch;
  PhysTag               commit_rw_tag;
  PhysTag               commit_old_tag;
  logic                 flush;
  logic [PHYS_REGS-1:0] phys_ready;
  logic [5:0]           free_count;

  register_rename_stage_if bus();

  register_rename_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .commit_valid   (commit_valid),
    .commit_rw_arch (commit_rw_arch),
    .commit_rw_tag  (commit_rw_tag),
    .commit_old_tag (commit_old_tag),
    .flush          (flush),
    .phys_ready     (phys_ready),
    .free_count     (free_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  PhysTag               m_map [ARCH_REGS];
  PhysTag               m_ret [ARCH_REGS];
  PhysTag               m_fl  [FL_DEPTH];
  logic [4:0]           m_head, m_tail, m_rhead;
  int                   m_count;
  logic [PHYS_REGS-1:0] m_ready;
  logic                 m_out_valid;
  RenamedOp             sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) begin
      m_map[i] = PhysTag'(i);
      m_ret[i] = PhysTag'(i);
    end
    for (int i = 0; i < FL_DEPTH; i++) m_fl[i] = PhysTag'(32 + i);
    m_head = '0; m_tail = '0; m_rhead = '0;
    m_count = 32;
    m_ready = '1;
    m_out_valid = 1'b0;
    sb.delete();
  endtask

  task automatic clear_inputs();
    bus.in_valid = 0; bus.in_uses_rs = 0; bus.in_rs_arch = '0;
    bus.in_uses_rt = 0; bus.in_rt_arch = '0; bus.in_uses_rw = 0; bus.in_rw_arch = '0;
    bus.iq_stall = 0; wb_valid = 0; wb_tag = '0; commit_valid = 0;
    commit_rw_arch = '0; commit_rw_tag = '0; commit_old_tag = '0; flush = 0;
  endtask

  task automatic set_instr(input logic urs, input ArchReg rs, input logic urt,
                           input ArchReg rt, input logic urw, input ArchReg rw);
    bus.in_valid = 1; bus.in_uses_rs = urs; bus.in_rs_arch = rs;
    bus.in_uses_rt = urt; bus.in_rt_arch = rt; bus.in_uses_rw = urw; bus.in_rw_arch = rw;
  endtask

  // Called just after the negedge with inputs driven; returns at posedge+1.
  task automatic tick();
    RenamedOp   e, got;
    logic       exp_ready, acc, alloc;
    PhysTag     alloc_tag;
    logic [4:0] diff;
    #1;
    exp_ready = !flush && (!m_out_valid || !bus.iq_stall) && (m_count != 0);
    check("in_ready", bus.in_ready, exp_ready);

    if (m_out_valid && !bus.iq_stall) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        got = '{bus.out_uses_rs, bus.out_rs_tag, bus.out_uses_rt, bus.out_rt_tag,
                bus.out_uses_rw, bus.out_rw_tag, bus.out_old_rw_tag};
        check("out_op", got, e);
      end
    end
    if (flush) sb.delete();

    acc       = bus.in_valid && exp_ready;
    alloc     = bus.in_uses_rw && (bus.in_rw_arch != 0);
    alloc_tag = m_fl[m_head];
    if (acc) begin
      e.uses_rs    = bus.in_uses_rs;
      e.rs_tag     = bus.in_uses_rs ? m_map[bus.in_rs_arch] : '0;
      e.uses_rt    = bus.in_uses_rt;
      e.rt_tag     = bus.in_uses_rt ? m_map[bus.in_rt_arch] : '0;
      e.uses_rw    = bus.in_uses_rw;
      e.rw_tag     = alloc ? alloc_tag : '0;
      e.old_rw_tag = alloc ? m_map[bus.in_rw_arch] : '0;
      sb.push_back(e);
    end

    if (flush) m_ready = '1;
    else begin
      if (wb_valid)     m_ready[wb_tag] = 1'b1;
      if (acc && alloc) m_ready[alloc_tag] = 1'b0;
    end
    m_ready[0] = 1'b1;

    if (commit_valid) begin
      m_fl[m_tail] = commit_old_tag;
      m_tail++; m_rhead++; m_count++;
      if (commit_rw_arch != 0) m_ret[commit_rw_arch] = commit_rw_tag;
    end
    if (acc && alloc) begin
      m_map[bus.in_rw_arch] = alloc_tag;
      m_head++; m_count--;
    end
    if (flush) begin
      m_map  = m_ret;
      m_head = m_rhead;
      diff   = m_tail - m_head;
      m_count = (diff == 0) ? 32 : int'(diff);
    end
    m_out_valid = flush ? 1'b0 : acc ? 1'b1 : (!bus.iq_stall ? 1'b0 : m_out_valid);

    @(posedge clk); #1;
    check("out_valid", bus.out_valid, m_out_valid);
    check("free_count", free_count, m_count);
    check("phys_ready", phys_ready, m_ready);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rename(input logic urs, input ArchReg rs, input logic urt,
                        input ArchReg rt, input logic urw, input ArchReg rw);
    @(negedge clk); clear_inputs();
    set_instr(urs, rs, urt, rt, urw, rw);
    tick();
  endtask

  task automatic idle();
    @(negedge clk); clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_free_count", free_count, 32);
    check("rst_phys_ready", phys_ready, {PHYS_REGS{1'b1}});
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_rw_tag", bus.out_rw_tag, 0);

    // add $3,$1,$2 then add $3,$3,$3
    rename(1, 5'd1, 1, 5'd2, 1, 5'd3);
    check("basic_rs", bus.out_rs_tag, 1);
    check("basic_rt", bus.out_rt_tag, 2);
    check("basic_rw", bus.out_rw_tag, 32);
    check("basic_old", bus.out_old_rw_tag, 3);
    check("basic_ready32", phys_ready[32], 0);
    rename(1, 5'd3, 1, 5'd3, 1, 5'd3);
    check("dep_rs", bus.out_rs_tag, 32);
    check("dep_rt", bus.out_rt_tag, 32);
    check("dep_rw", bus.out_rw_tag, 33);
    check("dep_old", bus.out_old_rw_tag, 32);

    // Writes to $0 never allocate; stall holds the output
    rename(1, 5'd0, 0, 5'd0, 1, 5'd0);
    check("r0_rw", bus.out_rw_tag, 0);
    check("r0_old", bus.out_old_rw_tag, 0);
    @(negedge clk); clear_inputs(); set_instr(0, 0, 0, 0, 1, 5'd9); bus.iq_stall = 1; tick();
    @(negedge clk); clear_inputs(); set_instr(0, 0, 0, 0, 1, 5'd9); bus.iq_stall = 1; tick();
    rename(0, 0, 0, 0, 1, 5'd9);
    check("after_stall_rw", bus.out_rw_tag, 34);
    idle();

    // Exhaustion and recovery (reset asserted mid-operation)
    rename(1, 5'd1, 0, 0, 1, 5'd7);
    do_reset();
    for (int i = 0; i < 32; i++) rename(1, 5'd5, 0, 0, 1, 5'd5);
    idle();
    check("exh_free_count", free_count, 0);
    @(negedge clk); clear_inputs(); set_instr(1, 5'd1, 0, 0, 0, 0);
    #1;
    check("exh_in_ready", bus.in_ready, 0);
    tick();
    @(negedge clk); clear_inputs();
    commit_valid = 1; commit_rw_arch = 5'd5; commit_rw_tag = 6'd32; commit_old_tag = 6'd5;
    tick();
    check("rec_free_count", free_count, 1);
    rename(0, 0, 0, 0, 1, 5'd6);
    check("rec_rw", bus.out_rw_tag, 5);
    check("rec_old", bus.out_old_rw_tag, 6);
    idle();

    // Flush rewinds to the committed state
    do_reset();
    for (int i = 0; i < 3; i++) rename(1, 5'd4, 0, 0, 1, 5'd4);
    @(negedge clk); clear_inputs();
    commit_valid = 1; commit_rw_arch = 5'd4; commit_rw_tag = 6'd32; commit_old_tag = 6'd4;
    tick();
    @(negedge clk); clear_inputs(); flush = 1; wb_valid = 1; wb_tag = 6'd40; tick();
    check("flush_ready", phys_ready, {PHYS_REGS{1'b1}});
    check("flush_free_count", free_count, 32);
    rename(1, 5'd4, 0, 0, 1, 5'd4);
    check("flush_map4", bus.out_rs_tag, 32);
    check("flush_next_alloc", bus.out_rw_tag, 33);
    idle();

    // Writeback in the same cycle as a dependent accept
    do_reset();
    rename(1, 5'd1, 1, 5'd2, 1, 5'd3);
    @(negedge clk); clear_inputs(); set_instr(1, 5'd3, 0, 0, 0, 0);
    wb_valid = 1; wb_tag = 6'd32;
    tick();
    check("bypass_ready32", phys_ready[32], 1);
    check("bypass_rs", bus.out_rs_tag, 32);
    idle();

    // Random traffic with stalls, writebacks and one flush
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); clear_inputs();
      if ($urandom_range(0, 3) != 0)
        set_instr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      bus.iq_stall = ($urandom_range(0, 2) == 0);
      wb_valid     = ($urandom_range(0, 1) == 0);
      wb_tag       = 6'($urandom_range(0, 63));
      flush        = (n == 30);
      tick();
    end
    idle();
    idle();
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
